// File: rtl/jtframe_scan_timer.sv
// Video scan timer: pixel clock enables, horizontal/vertical counters and registered sync/blanking.
// Optional composite sync output (HS ^ VS) is enabled by defining JTFRAME_SCAN_TIMER_CSYNC_EN.
module jtframe_scan_timer #(
  parameter int CENDIV   = 4,
  parameter int HLEN     = 384,
  parameter int HACT     = 256,
  parameter int HS_START = 288,
  parameter int HS_END   = 320,
  parameter int VLEN     = 262,
  parameter int VACT     = 224,
  parameter int VS_START = 234,
  parameter int VS_END   = 237,
  localparam int AW      = (HLEN <= 256) ? 8 : ((HLEN <= 512) ? 9 : 10)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          base_cen,
  output logic          basex2_cen,
  output logic [AW-1:0] hcnt,
  output logic [8:0]    vcnt,
  output logic          HS,
  output logic          VS,
  output logic          LHBL,
  output logic          LVBL
`ifdef JTFRAME_SCAN_TIMER_CSYNC_EN
  ,
  output logic          csync
`endif
);

  localparam int DW = $clog2(CENDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CENDIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CENDIV / 2);
  localparam logic [AW-1:0] H_LAST   = AW'(HLEN - 1);
  localparam logic [8:0]    V_LAST   = 9'(VLEN - 1);

  // Illegal timing sets stop elaboration instead of producing a broken raster.
  if (HS_END > HLEN || HACT >= HLEN || VACT >= VLEN ||
      CENDIV < 2 || (CENDIV % 2) != 0 || HLEN > 1024 || VLEN > 512) begin : g_param_check
    $error("jtframe_scan_timer: illegal timing parameter combination");
  end

  logic [DW-1:0] div_q, div_d;
  logic          base_cen_q, base_cen_d;
  logic          basex2_cen_q, basex2_cen_d;
  logic [AW-1:0] hcnt_q, hcnt_d;
  logic [8:0]    vcnt_q, vcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          lhbl_q, lhbl_d;
  logic          lvbl_q, lvbl_d;
`ifdef JTFRAME_SCAN_TIMER_CSYNC_EN
  logic          csync_q, csync_d;
`endif

  // Enables are registered from the next divider value so they are high
  // exactly in the cycle the divider holds 0 (and CENDIV/2 for the x2 enable).
  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    base_cen_d   = (div_d == '0);
    basex2_cen_d = (div_d == '0) || (div_d == DIV_HALF);

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (base_cen_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end

    // Decoded from the next counts so flags and counters change on the same edge.
    hs_d   = (int'(hcnt_d) >= HS_START) && (int'(hcnt_d) < HS_END);
    vs_d   = (int'(vcnt_d) >= VS_START) && (int'(vcnt_d) < VS_END);
    lhbl_d = (int'(hcnt_d) < HACT);
    lvbl_d = (int'(vcnt_d) < VACT);
`ifdef JTFRAME_SCAN_TIMER_CSYNC_EN
    csync_d = hs_d ^ vs_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      base_cen_q   <= 1'b0;
      basex2_cen_q <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      lhbl_q       <= 1'b1;
      lvbl_q       <= 1'b1;
`ifdef JTFRAME_SCAN_TIMER_CSYNC_EN
      csync_q      <= 1'b0;
`endif
    end else begin
      div_q        <= div_d;
      base_cen_q   <= base_cen_d;
      basex2_cen_q <= basex2_cen_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      lhbl_q       <= lhbl_d;
      lvbl_q       <= lvbl_d;
`ifdef JTFRAME_SCAN_TIMER_CSYNC_EN
      csync_q      <= csync_d;
`endif
    end
  end

  assign base_cen   = base_cen_q;
  assign basex2_cen = basex2_cen_q;
  assign hcnt       = hcnt_q;
  assign vcnt       = vcnt_q;
  assign HS         = hs_q;
  assign VS         = vs_q;
  assign LHBL       = lhbl_q;
  assign LVBL       = lvbl_q;
`ifdef JTFRAME_SCAN_TIMER_CSYNC_EN
  assign csync      = csync_q;
`endif

endmodule

// File: doc/jtframe_scan_timer.md
JTFRAME_SCAN_TIMER -- requirements
Module: jtframe_scan_timer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
 CENDIV, 4, clk cycles per base pixel; even, >=2
 HLEN, 384, total pixels per line
 HACT, 256, active pixels per line
 HS_START, 288, first hcnt with HS high
 HS_END, 320, first hcnt with HS low again
 VLEN, 262, total lines per frame
 VACT, 224, active lines per frame
 VS_START, 234, first vcnt with VS high
 VS_END, 237, first vcnt with VS low again
REQ-002 The block SHALL have these ports (name, direction, width, meaning); clock and reset first:
 clk  in  1  single system clock
 rst_n  in  1  reset; synchronous and active-low
 base_cen  out  1  one-clk pulse per base pixel
 basex2_cen  out  1  one-clk pulse at twice the base pixel rate
 hcnt  out  AW  horizontal pixel count, with AW = 8/9/10 for HLEN <= 256/512/1024
 vcnt  out  9  line count
 HS  out  1  horizontal sync, active high
 VS  out  1  vertical sync, active high
 LHBL  out  1  low during horizontal blanking
 LVBL  out  1  low during vertical blanking

Function
REQ-003 A divider SHALL count 0..CENDIV-1 and then wrap to 0.
REQ-004 base_cen SHALL be high only for the clk cycle in which the divider equals 0.
REQ-005 basex2_cen SHALL be high for the clk cycle in which the divider equals 0 and for the cycle in which it equals CENDIV/2, so that every base_cen pulse coincides with a basex2_cen pulse.
REQ-006 hcnt SHALL increment on each clk edge that samples base_cen high, wrapping from HLEN-1 to 0.
REQ-007 vcnt SHALL increment on the same edge on which hcnt wraps, wrapping from VLEN-1 to 0; when both wrap together, both SHALL read 0.
REQ-008 HS, VS, LHBL and LVBL SHALL be registered and SHALL be updated on the same edge as hcnt/vcnt, always reflecting the new count values with zero skew.
REQ-009 HS SHALL equal (HS_START <= hcnt < HS_END).
REQ-010 VS SHALL equal (VS_START <= vcnt < VS_END), and VS SHALL change only on an hcnt wrap.
REQ-011 LHBL SHALL equal (hcnt < HACT), and LVBL SHALL equal (vcnt < VACT).
REQ-012 Between base_cen edges, all outputs except the two cen signals SHALL hold their values.
REQ-013 The parameter combinations HS_END > HLEN, HACT >= HLEN or VACT >= VLEN SHALL be rejected at elaboration by a failed generate check.

Reset
REQ-014 While rst_n is low at a clk edge, the divider, hcnt and vcnt SHALL be set to 0.
REQ-015 While rst_n is low at a clk edge, base_cen, basex2_cen, HS and VS SHALL be set to 0, and LHBL and LVBL SHALL be set to 1.
REQ-016 Reset asserted mid-line or mid-frame SHALL take effect at the next clk edge with no partial-line completion.
REQ-017 The first base_cen after rst_n is released SHALL occur CENDIV clk cycles after the release edge.

Configuration
REQ-018 With JTFRAME_SCAN_TIMER_CSYNC_EN defined, the block SHALL add a 1-bit output csync, registered alongside HS/VS, equal to HS XOR VS, with reset value 0.
REQ-019 Without JTFRAME_SCAN_TIMER_CSYNC_EN defined, the port csync SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-020 Release reset with default parameters -> base_cen period is 4 clk, basex2_cen period is 2 clk, and the first base_cen occurs 4 clk after release.
REQ-021 Run one full line -> HS rises at hcnt=288, HS falls at hcnt=320, LHBL falls at hcnt=256 and rises at hcnt=0, and the line is 1536 clk long.
REQ-022 Run one full frame -> VS is high for vcnt 234..236, LVBL is low for vcnt 224..261, and the frame is 262*384*4 = 402432 clk long.
REQ-023 At hcnt=383, vcnt=261 followed by base_cen -> hcnt=0, vcnt=0, LVBL=1 and LHBL=1 on the same edge.
REQ-024 Assert rst_n low at hcnt=300 while HS=1 -> at the next edge HS=0, hcnt=0 and vcnt=0, and counting resumes correctly after release.
REQ-025 With JTFRAME_SCAN_TIMER_CSYNC_EN defined, at vcnt=235 -> csync is the inverse of HS across the whole line; at vcnt=100 -> csync equals HS.
